reg_write_arbiter: RTL
======================

Name: reg_write_arbiter

Overview:
- Shares one write port of a register bank (an array of DFF_REG instances, one write enable per address) among NUM_REQ requesters.
- Arbitration is round-robin. Each transfer uses a level-request / single-cycle-acknowledge handshake.
- Drives one registered write strobe with address and data per granted transfer.
- Sits between the control-side blocks (command decoder, calibration sequencer, host bridge) and the configuration register bank.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- ADDR_WIDTH, 4: register address width.
- DATA_WIDTH, 16: register data width.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- iREQ  input  NUM_REQ  per-requester write request; level.
- iADDR  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- iDATA  input  NUM_REQ*DATA_WIDTH  packed data; requester k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
- oACK  output  NUM_REQ  one-hot, single-cycle acknowledge to the served requester.
- oWE  output  1  write strobe to the register bank; single cycle.
- oWADDR  output  ADDR_WIDTH  write address; valid while oWE=1.
- oWDATA  output  DATA_WIDTH  write data; valid while oWE=1.
- oGNT_ID  output  $clog2(NUM_REQ)  index of the last granted requester.
- oBUSY  output  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset, sampled on a CLK edge while RST=1:
  - state=IDLE, round-robin pointer=0.
  - oACK=0, oWE=0, oWADDR=0, oWDATA=0, oGNT_ID=0, oBUSY=0.
- State machine: IDLE -> WRITE -> RELEASE -> IDLE.
- IDLE:
  - If any iREQ bit is set, select the first set bit searching upward from the pointer and wrapping modulo NUM_REQ.
  - Latch that requester's address and data into oWADDR/oWDATA, set oGNT_ID=g, go to WRITE.
  - If no request is set, stay in IDLE with all outputs unchanged except oWE/oACK=0.
- WRITE, exactly one cycle:
  - oWE=1 and oACK[g]=1 in the same cycle.
  - Pointer <= (g+1) mod NUM_REQ.
  - Next state RELEASE.
- RELEASE, exactly one cycle:
  - oWE=0, oACK=0, no arbitration.
  - Gives the served requester one cycle to deassert iREQ. Next state IDLE.
- Latency: iREQ sampled high in IDLE at edge N -> oWE/oACK high in cycle N+1.
- Minimum period between grants: 3 cycles.
- Requester protocol:
  - Hold iADDR/iDATA stable while iREQ=1 until oACK is seen.
  - Drop iREQ in the cycle after oACK. If iREQ is still high in IDLE, it is a new request.
- iREQ deasserted before it is granted: the request is withdrawn, with no ack and no write.
- Simultaneous requests: exactly one grant per WRITE. With all requests held, each requester is served once per NUM_REQ grants.
- oWADDR/oWDATA/oGNT_ID hold their last values outside WRITE.
- Reset mid-operation (RST=1 during WRITE or RELEASE):
  - Next state is IDLE and outputs go to their reset values.
  - A write already strobed is not retracted.
  - A pending requester keeps iREQ high and is re-arbitrated from pointer 0.
- Only the bits of iREQ below NUM_REQ exist; no out-of-range grant is possible.

Optional Feature:
- Macro: REG_WRITE_ARB_STRICT_PRIO_EN.
- Defined:
  - Fixed priority, requester 0 highest. The search always starts at index 0 and the pointer is not used or updated.
  - Starvation of high-index requesters is permitted.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: assert RST for 2 cycles while iREQ=4'b1111 -> oWE=0, oACK=0, oBUSY=0, oWADDR=0, oWDATA=0 throughout; first grant goes to requester 0 after RST falls.
- Single request: iREQ[2]=1, addr 4'h5, data 16'hA5A5 sampled at edge N -> cycle N+1: oWE=1, oWADDR=5, oWDATA=A5A5, oACK=4'b0100, oGNT_ID=2; cycle N+2: oWE=0, oBUSY=1; cycle N+3: oBUSY=0.
- Round-robin fairness: iREQ=4'b1111 held, each requester dropping its request after its ack and re-raising it 1 cycle later -> grant order 0,1,2,3,0,1 with grants 3 cycles apart. With the macro defined, every grant goes to requester 0.
- Withdrawal: iREQ[1] pulsed for 1 cycle while a write to requester 3 is in WRITE -> no ack to requester 1, no extra oWE.
- Stuck request: requester 0 keeps iREQ high after its ack, others idle -> requester 0 is re-granted every 3 cycles and receives a new oACK each time.
- Reset mid-write: RST=1 in the WRITE cycle of requester 2 while iREQ=4'b0110 -> next cycle all outputs are at reset values; after release, requester 1 is granted first (pointer=0).

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Shares one register-bank write port among NUM_REQ requesters; round-robin, or fixed priority with REG_WRITE_ARB_STRICT_PRIO_EN.
// Request sampled in IDLE -> oWE/oACK next cycle; one grant per 3 cycles; requesters wait on level iREQ until oACK.
module reg_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            iREQ,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] iADDR,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] iDATA,
  output logic [NUM_REQ-1:0]            oACK,
  output logic                          oWE,
  output logic [ADDR_WIDTH-1:0]         oWADDR,
  output logic [DATA_WIDTH-1:0]         oWDATA,
  output logic [$clog2(NUM_REQ)-1:0]    oGNT_ID,
  output logic                          oBUSY
);

  localparam int PW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WRITE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [PW-1:0]         gnt_q, gnt_d;
  logic                  busy_q, busy_d;

  logic [PW-1:0]         base;
  logic [PW-1:0]         sel;
  logic                  found;
  logic [PW:0]           scan_idx;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k] = iADDR[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[k] = iDATA[k*DATA_WIDTH +: DATA_WIDTH];
  end

`ifdef REG_WRITE_ARB_STRICT_PRIO_EN
  assign base = '0;
`else
  logic [PW-1:0] ptr_q, ptr_d;
  assign base = ptr_q;
`endif

  // Scan upward from base, wrapping at NUM_REQ; scan_idx never exceeds 2*NUM_REQ-2.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = {1'b0, base} + (PW+1)'(i);
      if (scan_idx >= (PW+1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (PW+1)'(NUM_REQ);
      end
      if (!found && iREQ[scan_idx[PW-1:0]]) begin
        found = 1'b1;
        sel   = scan_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    gnt_d   = gnt_q;
`ifndef REG_WRITE_ARB_STRICT_PRIO_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d    = S_WRITE;
          we_d       = 1'b1;
          ack_d[sel] = 1'b1;
          waddr_d    = addr_arr[sel];
          wdata_d    = data_arr[sel];
          gnt_d      = sel;
        end
      end
      S_WRITE: begin
        state_d = S_RELEASE;
`ifndef REG_WRITE_ARB_STRICT_PRIO_EN
        ptr_d   = (gnt_q == PW'(NUM_REQ-1)) ? '0 : gnt_q + PW'(1);
`endif
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ack_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
`ifndef REG_WRITE_ARB_STRICT_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
`ifndef REG_WRITE_ARB_STRICT_PRIO_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  assign oACK    = ack_q;
  assign oWE     = we_q;
  assign oWADDR  = waddr_q;
  assign oWDATA  = wdata_q;
  assign oGNT_ID = gnt_q;
  assign oBUSY   = busy_q;

endmodule
